// File: rtl/timer_pkg.sv
// Shared constants and types for the minutes/seconds timer digit counters.
package timer_pkg;

    // Every timer digit is one BCD nibble.
    localparam int DIGIT_W = 4;

    // The tens-of-seconds digit counts 5..0; the units digits count 9..0.
    localparam int MOD_SEC_TENS  = 6;
    localparam int MOD_SEC_UNITS = 10;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage : timer_pkg

// File: rtl/counter_modn.sv
// Generic modulo-MOD BCD down counter.
// It has a saturating parallel load and zero/borrow flags for cascading.
// The same counter serves the mod-6 tens digit and the mod-10 units digits.
module counter_modn #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clock,
    input  logic         clearn,
    input  logic         loadn,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [W-1:0] digit,
    output logic         zero,
    output logic         tc
);

    // Largest legal count. Both the wrap value and the load saturation value.
    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    logic [W-1:0] digit_q;
    logic [W-1:0] digit_d;

    // Next count: a load takes priority over counting, and counting takes priority over holding.
    // A load above the legal range is clamped, so the register never holds an illegal digit.
    always_comb begin
        digit_d = digit_q;
        if (!loadn) begin
            digit_d = (data > MAX_VAL) ? MAX_VAL : data;
        end else if (en) begin
            digit_d = (digit_q == '0) ? MAX_VAL : (digit_q - W'(1));
        end
    end

    // Digit register: clearn empties it at once; other changes wait for a clock edge.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign zero  = (digit_q == '0);
    // tc is the borrow to the next-higher digit.
    // It is high in the cycle before this digit wraps 0 -> MAX.
    assign tc    = en & zero;

    // The register must never leave the legal range 0..MOD-1.
    digitInRange: assert property (@(posedge clock) disable iff (!clearn) digit_q <= MAX_VAL);

endmodule : counter_modn

// File: rtl/counter_mod6.sv
// Tens-of-seconds digit of the timer.
// It is the generic BCD down counter with the modulus set to 6.
module counter_mod6
    import timer_pkg::*;
#(
    parameter int MOD = MOD_SEC_TENS,
    parameter int W   = DIGIT_W
) (
    input  logic         clock,
    input  logic         clearn,
    input  logic         loadn,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [W-1:0] digit,
    output logic         zero,
    output logic         tc
);

    counter_modn #(
        .MOD (MOD),
        .W   (W)
    ) uCounter (
        .clock  (clock),
        .clearn (clearn),
        .loadn  (loadn),
        .en     (en),
        .data   (data),
        .digit  (digit),
        .zero   (zero),
        .tc     (tc)
    );

endmodule : counter_mod6

// File: tb/tb_counter_mod6.sv
// Self-checking bench for counter_mod6.
// The reference model predicts the digit from the counting rules with plain arithmetic.
`timescale 1us/1ns
module tb_counter_mod6;

    logic       clock;
    logic       clearn;
    logic       loadn;
    logic       en;
    logic [3:0] data;
    logic [3:0] digit;
    logic       zero;
    logic       tc;

    int testCount;
    int errorCount;
    int modelDigit;
    bit checkEn;

    counter_mod6 dut (
        .clock  (clock),
        .clearn (clearn),
        .loadn  (loadn),
        .en     (en),
        .data   (data),
        .digit  (digit),
        .zero   (zero),
        .tc     (tc)
    );

    // The clock period is 10 us.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference digit: cleared asynchronously, else a saturating load,
    // else a decrement modulo 6, else a hold.
    always @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            modelDigit <= 0;
        end else if (!loadn) begin
            modelDigit <= (int'(data) > 5) ? 5 : int'(data);
        end else if (en) begin
            modelDigit <= (modelDigit + 5) % 6;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive the inputs now, which is just after a rising edge.
    // Then advance by the given number of edges and stop again just after the last one.
    task automatic applyStimulus(input logic cl, input logic ld, input logic e,
                                 input logic [3:0] d, input int cycles);
        clearn = cl;
        loadn  = ld;
        en     = e;
        data   = d;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    // Compare the outputs with the model on every falling edge, away from the active edge.
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("digit", int'(digit), modelDigit);
            checkOutput("zero", int'(zero), (modelDigit == 0) ? 1 : 0);
            checkOutput("tc", int'(tc), (en && modelDigit == 0) ? 1 : 0);
        end
    end

    initial begin
        int expSeq[15];
        testCount  = 0;
        errorCount = 0;
        checkEn    = 1'b0;
        clearn     = 1'b0;
        loadn      = 1'b0;
        en         = 1'b0;
        data       = 4'd0;
        #2;
        clearn     = 1'b1;
        checkEn    = 1'b1;
        @(posedge clock);
        #1;

        // Load 0 for 10 cycles, then hold for 5 cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 10);
        checkOutput("resetDigit", int'(digit), 0);
        checkOutput("resetZero", int'(zero), 1);
        checkOutput("resetTc", int'(tc), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 5);
        checkOutput("holdDigit", int'(digit), 0);

        // Count down from 0. tc is high before the first edge, and the digit wraps to 5.
        expSeq = '{5, 4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5, 4, 3};
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 0);
        checkOutput("firstTc", int'(tc), 1);
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            #1;
            checkOutput("countSeq", int'(digit), expSeq[i]);
            checkOutput("countTc", int'(tc), (expSeq[i] == 0) ? 1 : 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 3);
        checkOutput("frozen", int'(digit), 3);

        // A clear in the middle of a count takes effect before the next edge.
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 0);
        checkOutput("asyncClear", int'(digit), 0);
        checkOutput("asyncClearTc", int'(tc), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 5);
        checkOutput("clearHeld", int'(digit), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 1);
        checkOutput("afterClear1", int'(digit), 5);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 2);
        checkOutput("afterClear3", int'(digit), 3);

        // A load wins over counting. Counting then resumes from the loaded value.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd4, 1);
        checkOutput("load4", int'(digit), 4);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, 4);
        checkOutput("load4Down", int'(digit), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, 1);
        checkOutput("load4Wrap", int'(digit), 5);

        // A load above the legal range saturates to 5. A load of 0 sets zero.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd9, 1);
        checkOutput("loadSat", int'(digit), 5);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1);
        checkOutput("load0", int'(digit), 0);
        checkOutput("load0Zero", int'(zero), 1);

        // A clear overrides a simultaneous load. The load applies on the first edge after release.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd3, 2);
        checkOutput("clearOverLoad", int'(digit), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 1);
        checkOutput("loadAfterClear", int'(digit), 3);

        // Random traffic, checked against the model by the falling-edge compare process.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 24) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                          4'($urandom_range(0, 15)), 1);
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testCount, errorCount);
        $finish;
    end

endmodule : tb_counter_mod6

// File: doc/counter_mod6.md
Name: counter_mod6

Overview:
- Single BCD-digit synchronous down counter, modulo 6, for the tens-of-seconds digit of the minutes/seconds timer.
- Counts 5→4→…→0→5 when enabled.
- Parallel-loadable from a preset digit; flags zero and terminal count for cascading to the minutes digit and to the timer-done logic.
- One clock domain; asynchronous active-low clear.

Parameters:
- MOD, 6, counter modulus; legal count range is 0..MOD-1.
- W, 4, digit width in bits; BCD digit.

Ports:
- clock  in  1  system clock, rising edge active.
- clearn  in  1  asynchronous active-low reset/clear.
- loadn  in  1  synchronous active-low parallel load.
- en  in  1  count enable; decrement on a clock edge when high.
- data  in  W  preset value loaded when loadn is low.
- digit  out  W  current count value, registered.
- zero  out  1  high when digit == 0, combinational from the register.
- tc  out  1  terminal count (borrow): high when en == 1 and digit == 0, combinational.

Behaviour:
- Interface: one clock, named clock. Reset is asynchronous and active-low, named clearn.
- Reset: clearn low forces digit = 0 immediately, independent of clock.
  - While clearn is low: zero = 1; tc = en.
  - Release is synchronous in effect: operations resume on the first rising edge after clearn returns high.
- Priority on a rising edge with clearn high: loadn low (load) > en high (count) > hold.
- Load: digit <= data when data <= MOD-1; if data > MOD-1, digit <= MOD-1 (saturate to 5).
  - Load takes effect on the edge; digit updates 1 cycle after sampling.
  - en is ignored while loadn is low.
- Count: en high and loadn high.
  - digit > 0 → digit <= digit - 1.
  - digit == 0 → digit <= MOD-1 (wrap 0 → 5).
- Hold: en low and loadn high → digit unchanged.
- zero = (digit == 0), regardless of en.
- tc = en & (digit == 0). It asserts during the cycle in which the next enabled edge wraps 0 → 5, so a higher-order digit decrements on the same edge.
- Illegal digit state is unreachable: reset gives 0, load saturates, wrap gives MOD-1.
- Simultaneous events:
  - clearn low overrides loadn and en.
  - loadn low with en high → load only; tc still reflects en & zero for that cycle.
- Reset mid-count clears to 0 asynchronously. Counting resumes from 0, wrapping to 5 on the next enabled edge.
- Scope: a small core (well under 120 lines) is acceptable. The 120-400 range is met only if the optional shared package, assertions or a cascade wrapper are included.

Decomposition:
- Shared package timer_pkg:
  - constant DIGIT_W = 4
  - constants MOD_SEC_TENS = 6 and MOD_SEC_UNITS = 10
  - typedef bcd_digit_t (4-bit)
- One generic sub-module, counter_modn (MOD parameter), with counter_mod6 as a thin parameterised instance. counter_modn is reused for the mod-10 units digits.
- No FSM beyond the counter register.

Test Plan:
- Clock period 10 us. clearn=1, loadn=0, en=0, data=0 for 10 cycles → digit=0, zero=1, tc=0. Then loadn=1, hold 5 cycles → digit stays 0.
- From digit=0, en=1 for 15 cycles → tc=1 in the first cycle. Digits after successive edges: 5,4,3,2,1,0,5,4,… with zero=1 and tc=1 exactly when digit==0. en=0 → digit frozen.
- clearn pulsed low for 5 cycles mid-count (digit=3) → digit=0 immediately, before the next edge. After release with en=1 → 5,4,3…
- loadn=0 with data=4, en=1 → digit=4 after one edge, with no decrement that cycle. loadn=1 → 3,2,1,0,5.
- data=9 with loadn=0 → digit=5 (saturated). data=0 load → digit=0, zero=1.
- Simultaneous clearn=0 and loadn=0, data=3 → digit stays 0 until clearn=1. The next edge with loadn still low gives digit=3.
